// File: rtl/imm_enc_pkg.sv
// Shared constants, instruction layout and range-check helpers for the immediate encoder.
package imm_enc_pkg;

    localparam int INSTR_W = 30;
    localparam int OP_W    = 5;
    localparam int P1_W    = 15;
    localparam int P2_W    = 10;

    localparam logic [OP_W-1:0] OP_ZEXT10 = 5'b10111;
    localparam logic [OP_W-1:0] OP_SEXT17 = 5'b01000;
    localparam logic [OP_W-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OP_W-1:0] OP_SEXT15 = 5'b00100;

    // Ascending field ranges: index 0 is the MSB, matching the decoder's view.
    typedef struct packed {
        logic [0:OP_W-1] opcode;
        logic [0:P1_W-1] p1;
        logic [0:P2_W-1] p2;
    } instr_t;

    // True when every bit at or above lsb is zero.
    function automatic logic zext_fits(input logic [31:0] v, input int unsigned lsb);
        return (v >> lsb) == 32'd0;
    endfunction

    // True when bits [31:lsb] are all equal (value fits a signed field of lsb+1 bits).
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] upper;
        upper = v >> lsb;
        return (upper == 32'd0) || (upper == (32'hFFFF_FFFF >> lsb));
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packing of a 32-bit immediate into the P1/P2 fields plus range check.
module imm_field_pack
    import imm_enc_pkg::*;
(
    input  logic [0:OP_W-1] opcode_i,
    input  logic [0:31]     imm_i,
    input  logic [0:P1_W-1] base_p1_i,
    input  logic [0:P2_W-1] base_p2_i,
    output instr_t          instr_o,
    output logic            range_err_o
);

    logic [31:0]     v;
    logic [0:P1_W-1] p1;
    logic [0:P2_W-1] p2;
    logic            err;

    // imm_i[0] is the MSB, so a positional copy gives v[k] = weight 2^k.
    assign v = imm_i;

    always_comb begin
        p1  = base_p1_i;
        p2  = base_p2_i;
        err = 1'b0;
        case (opcode_i)
            OP_ZEXT10: begin
                p2[0:9] = v[9:0];
                err     = !zext_fits(v, 10);
            end
            OP_SEXT17: begin
                p1[0:6] = v[16:10];
                p2[0:9] = v[9:0];
                err     = !sext_fits(v, 16);
            end
            OP_BRANCH: begin
                p1[0]   = v[11];
                p2[4]   = v[10];
                p1[1:6] = v[9:4];
                p2[0:3] = v[3:0];
                err     = !sext_fits(v, 11);
            end
            OP_SEXT15: begin
                p1[0:14] = v[14:0];
                err      = !sext_fits(v, 14);
            end
            default: begin
                p1  = base_p1_i;
                p2  = base_p2_i;
                err = 1'b0;
            end
        endcase
    end

    assign instr_o.opcode = opcode_i;
    assign instr_o.p1     = p1;
    assign instr_o.p2     = p2;
    assign range_err_o    = err;

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with one output register and auto-incrementing write address.
// Define IMM_ENC_ERR_CNT_EN to build the saturating range-error counter.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:4]           in_opcode,
    input  logic [0:31]          in_imm,
    input  logic [0:14]          in_base_p1,
    input  logic [0:9]           in_base_p2,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    start_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:INSTR_W-1]   out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_range_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    instr_t              enc_instr;
    logic                enc_err;
    logic                accept;
    logic                out_hs;

    logic                valid_q, valid_d;
    instr_t              instr_q, instr_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    imm_field_pack u_pack (
        .opcode_i    (in_opcode),
        .imm_i       (in_imm),
        .base_p1_i   (in_base_p1),
        .base_p2_i   (in_base_p2),
        .instr_o     (enc_instr),
        .range_err_o (enc_err)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            instr_d = enc_instr;
            err_d   = enc_err;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
    end

    // A load takes priority over the post-handshake increment.
    always_comb begin
        addr_d = addr_q;
        if (addr_load) begin
            addr_d = start_addr;
        end else if (out_hs) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_instr     = instr_q;
    assign out_range_err = err_q;
    assign out_addr      = addr_q;

`ifdef IMM_ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && err_q && (cnt_q != {ERR_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized streaming against a transaction model.
module tb_imm_encoder;

    localparam int ADDR_W    = 10;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef IMM_ENC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [0:4]           in_opcode;
    logic [0:31]          in_imm;
    logic [0:14]          in_base_p1;
    logic [0:9]           in_base_p2;
    logic                 addr_load;
    logic [ADDR_W-1:0]    start_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:29]          out_instr;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_range_err;
    logic [ERR_CNT_W-1:0] err_count;

    imm_encoder #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_imm       (in_imm),
        .in_base_p1   (in_base_p1),
        .in_base_p2   (in_base_p2),
        .addr_load    (addr_load),
        .start_addr   (start_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_addr     (out_addr),
        .out_range_err(out_range_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] instr;
        logic        err;
    } word_t;

    int    vectors     = 0;
    int    miscompares = 0;
    word_t exp_q[$];
    int    exp_addr = 0;
    int    exp_cnt  = 0;
    logic [4:0] ops [4] = '{5'b10111, 5'b01000, 5'b11000, 5'b00100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: fields built as plain integers (P1 weight 2^(14-i), P2 weight 2^(9-i)).
    function automatic void model_enc(input logic [4:0] op, input logic [31:0] imm,
                                      input logic [14:0] b1, input logic [9:0] b2,
                                      output logic [29:0] w, output logic err);
        longint    s;
        logic [14:0] p1;
        logic [9:0]  p2;
        s   = longint'($signed(imm));
        p1  = b1;
        p2  = b2;
        err = 1'b0;
        case (op)
            5'b10111: begin
                p2  = 10'(imm & 32'h3FF);
                err = imm > 32'd1023;
            end
            5'b01000: begin
                p1  = (b1 & 15'h00FF) | 15'(((imm >> 10) & 32'h7F) << 8);
                p2  = 10'(imm & 32'h3FF);
                err = (s < -65536) || (s > 65535);
            end
            5'b11000: begin
                p1  = (b1 & 15'h00FF) | 15'(((imm >> 11) & 32'h1) << 14)
                                      | 15'(((imm >> 4) & 32'h3F) << 8);
                p2  = (b2 & 10'h01F)  | 10'((imm & 32'hF) << 6)
                                      | 10'(((imm >> 10) & 32'h1) << 5);
                err = (s < -2048) || (s > 2047);
            end
            5'b00100: begin
                p1  = 15'(imm & 32'h7FFF);
                err = (s < -16384) || (s > 16383);
            end
            default: ;
        endcase
        w = {op, p1, p2};
    endfunction

    // Decoder view of a branch word, used for the round-trip check.
    function automatic logic [31:0] dec_branch(input logic [29:0] w);
        logic [11:0] f;
        f = {w[24], w[5], w[23:18], w[9:6]};
        return {{20{f[11]}}, f};
    endfunction

    // One clock cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step(input logic iv, input logic [4:0] op, input logic [31:0] imm,
                        input logic [14:0] b1, input logic [9:0] b2,
                        input logic ordy, input logic al, input logic [ADDR_W-1:0] sa);
        logic  exp_ready;
        logic  hs;
        word_t wd;
        in_valid   = iv;
        in_opcode  = op;
        in_imm     = imm;
        in_base_p1 = b1;
        in_base_p2 = b2;
        out_ready  = ordy;
        addr_load  = al;
        start_addr = sa;
        @(negedge clk);
        exp_ready = (exp_q.size() == 0) || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_instr", 32'(out_instr), 32'(exp_q[0].instr));
            chk("out_range_err", 32'(out_range_err), 32'(exp_q[0].err));
        end
        chk("out_addr", 32'(out_addr), 32'(exp_addr));
        chk("err_count", 32'(err_count), 32'(exp_cnt));
        hs = (exp_q.size() != 0) && ordy;
        if (hs) begin
            if (CNT_EN && exp_q[0].err && exp_cnt < CNT_MAX) exp_cnt++;
            void'(exp_q.pop_front());
        end
        if (al) exp_addr = int'(sa);
        else if (hs) exp_addr = (exp_addr + 1) % (1 << ADDR_W);
        if (iv && exp_ready) begin
            model_enc(op, imm, b1, b2, wd.instr, wd.err);
            exp_q.push_back(wd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 32'd0, 15'd0, 10'd0, ordy, 1'b0, '0);
    endtask

    task automatic rand_step(input int ready_pct, input int load_pct);
        logic [4:0]  op;
        logic [31:0] imm;
        int          r;
        r  = int'($urandom_range(0, 4));
        op = (r < 4) ? ops[r] : 5'($urandom);
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       imm = 32'($urandom_range(0, 131071)) - 32'd65536;
            default: imm = 32'($urandom_range(0, 65535)) - 32'd32768;
        endcase
        step(1'($urandom_range(0, 99) < 80), op, imm, 15'($urandom), 10'($urandom),
             1'($urandom_range(0, 99) < ready_pct), 1'($urandom_range(0, 99) < load_pct),
             ADDR_W'($urandom));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_imm     = '0;
        in_base_p1 = '0;
        in_base_p2 = '0;
        out_ready  = 1'b1;
        addr_load  = 1'b0;
        start_addr = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_range_err", 32'(out_range_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed encodings from the test plan.
        step(1'b1, 5'b10111, 32'h0000_03FF, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("zext_max_instr", 32'(out_instr), 32'({5'b10111, 15'h0000, 10'h3FF}));
        chk("zext_max_err", 32'(out_range_err), 32'd0);
        step(1'b1, 5'b10111, 32'h0000_0400, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("zext_ovf_instr", 32'(out_instr), 32'({5'b10111, 15'h0000, 10'h000}));
        chk("zext_ovf_err", 32'(out_range_err), 32'd1);
        step(1'b1, 5'b11000, 32'hFFFF_FFFC, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("branch_m4_instr", 32'(out_instr), 32'({5'b11000, 15'h7F00, 10'h320}));
        chk("branch_m4_err", 32'(out_range_err), 32'd0);
        chk("branch_m4_roundtrip", dec_branch(out_instr), 32'hFFFF_FFFC);
        step(1'b1, 5'b01000, 32'h0000_FFFF, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("sext17_max_instr", 32'(out_instr), 32'({5'b01000, 15'h3F00, 10'h3FF}));
        chk("sext17_max_err", 32'(out_range_err), 32'd0);
        step(1'b1, 5'b01000, 32'h0001_0000, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("sext17_ovf_instr", 32'(out_instr), 32'({5'b01000, 15'h4000, 10'h000}));
        chk("sext17_ovf_err", 32'(out_range_err), 32'd1);
        step(1'b1, 5'b00001, 32'hDEAD_BEEF, 15'h1234, 10'h2AB, 1'b1, 1'b0, '0);
        chk("other_op_instr", 32'(out_instr), 32'({5'b00001, 15'h1234, 10'h2AB}));
        chk("other_op_err", 32'(out_range_err), 32'd0);
        idle(1'b1);

        // Backpressure: three requests, consumer stalls two cycles after the first word.
        step(1'b0, 5'd0, 32'd0, 15'd0, 10'd0, 1'b1, 1'b1, '0);
        step(1'b1, 5'b00100, 32'h0000_1111, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        step(1'b1, 5'b00100, 32'h0000_2222, 15'd0, 10'd0, 1'b0, 1'b0, '0);
        step(1'b1, 5'b00100, 32'h0000_2222, 15'd0, 10'd0, 1'b0, 1'b0, '0);
        chk("bp_hold_instr", 32'(out_instr), 32'({5'b00100, 15'h1111, 10'h000}));
        chk("bp_hold_addr", 32'(out_addr), 32'd0);
        step(1'b1, 5'b00100, 32'h0000_2222, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("bp_second_addr", 32'(out_addr), 32'd1);
        step(1'b1, 5'b00100, 32'h0000_3333, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("bp_third_addr", 32'(out_addr), 32'd2);
        idle(1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Address wrap from 2^ADDR_W-2.
        step(1'b0, 5'd0, 32'd0, 15'd0, 10'd0, 1'b1, 1'b1, ADDR_W'(1022));
        step(1'b1, 5'b10111, 32'd1, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("wrap_addr0", 32'(out_addr), 32'd1022);
        step(1'b1, 5'b10111, 32'd2, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("wrap_addr1", 32'(out_addr), 32'd1023);
        step(1'b1, 5'b10111, 32'd3, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        chk("wrap_addr2", 32'(out_addr), 32'd0);
        idle(1'b1);

        // Load coinciding with a handshake, and retargeting a stalled word.
        step(1'b1, 5'b10111, 32'd7, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        step(1'b0, 5'd0, 32'd0, 15'd0, 10'd0, 1'b1, 1'b1, ADDR_W'(100));
        chk("load_wins_addr", 32'(out_addr), 32'd100);
        step(1'b1, 5'b10111, 32'd8, 15'd0, 10'd0, 1'b0, 1'b0, '0);
        step(1'b0, 5'd0, 32'd0, 15'd0, 10'd0, 1'b0, 1'b1, ADDR_W'(500));
        chk("retarget_addr", 32'(out_addr), 32'd500);
        idle(1'b1);

        for (int i = 0; i < 400; i++) rand_step(70, 3);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // 300 erroring words to drive the counter into saturation.
        for (int i = 0; i < 300; i++)
            step(1'b1, 5'b10111, 32'h0000_0400 | $urandom, 15'd0, 10'd0, 1'b1, 1'b0, '0);
        idle(1'b1);
        chk("err_count_sat", 32'(err_count), CNT_EN ? 32'(CNT_MAX) : 32'd0);

        // Reset in the middle of a stalled transfer drops the word.
        step(1'b1, 5'b10111, 32'h0000_0800, 15'd0, 10'd0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_out_addr", 32'(out_addr), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        exp_addr = 0;
        exp_cnt  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) rand_step(85, 2);
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
